// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - RV32I decode stage with operand forwarding, load-use stall and registered ID/EX slot
module decode_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int PC_WIDTH  = 32,
    parameter int NUM_FWD   = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [PC_WIDTH-1:0]     pc_i,
    input  logic [31:0]             instr_i,
    output logic [4:0]              rs1_idx_o,
    output logic [4:0]              rs2_idx_o,
    input  logic [XLEN-1:0]         rs1_rdata_i,
    input  logic [XLEN-1:0]         rs2_rdata_i,
    input  logic [NUM_FWD-1:0]      fwd_rd_en_i,
    input  logic [5*NUM_FWD-1:0]    fwd_rd_idx_i,
    input  logic [XLEN*NUM_FWD-1:0] fwd_rd_wdata_i,
    input  logic [NUM_FWD-1:0]      fwd_is_load_i,
    input  logic                    flush_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [PC_WIDTH-1:0]     out_pc_o,
    output logic [31:0]             out_instr_o,
    output logic [XLEN-1:0]         out_rs1_rdata_o,
    output logic [XLEN-1:0]         out_rs2_rdata_o,
    output logic [XLEN-1:0]         out_imm_o,
    output logic [4:0]              out_rd_idx_o,
    output logic                    out_rd_en_o,
    output logic                    out_illegal_o,
    output logic [CNT_WIDTH-1:0]    stall_cnt_o
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic            rs1_en;
    logic            rs2_en;
    logic            rd_sel;
    logic            rd_en;
    logic            illegal;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            rs1_load;
    logic            rs2_load;
    logic            hazard;

    assign opcode    = instr_i[6:0];
    assign rd        = instr_i[11:7];
    assign rs1_idx_o = instr_i[19:15];
    assign rs2_idx_o = instr_i[24:20];

    always_comb begin
        rs1_en  = 1'b0;
        rs2_en  = 1'b0;
        rd_sel  = 1'b0;
        illegal = 1'b0;
        imm     = '0;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                rs1_en = 1'b1;
                rd_sel = 1'b1;
                imm    = XLEN'($signed(instr_i[31:20]));
            end
            OPC_OP: begin
                rs1_en = 1'b1;
                rs2_en = 1'b1;
                rd_sel = 1'b1;
            end
            OPC_BRANCH: begin
                rs1_en = 1'b1;
                rs2_en = 1'b1;
                imm    = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                        instr_i[11:8], 1'b0}));
            end
            OPC_JAL: begin
                rd_sel = 1'b1;
                imm    = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                        instr_i[30:21], 1'b0}));
            end
            OPC_LUI, OPC_AUIPC: begin
                rd_sel = 1'b1;
                imm    = XLEN'($signed({instr_i[31:12], 12'b0}));
            end
            OPC_SYSTEM: begin
                rd_sel = 1'b1;
                rs1_en = ~instr_i[14];
            end
            OPC_STORE: begin
                rs1_en = 1'b1;
                rs2_en = 1'b1;
                imm    = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
            end
            default: illegal = 1'b1;
        endcase
    end

    assign rd_en = rd_sel & (rd != 5'd0);

    // Walk from lowest priority upward so the lowest matching source wins.
    always_comb begin
        rs1_val  = rs1_rdata_i;
        rs2_val  = rs2_rdata_i;
        rs1_load = 1'b0;
        rs2_load = 1'b0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_rd_en_i[k] && rs1_en && (rs1_idx_o != 5'd0) &&
                (rs1_idx_o == fwd_rd_idx_i[5*k +: 5])) begin
                rs1_val  = fwd_rd_wdata_i[XLEN*k +: XLEN];
                rs1_load = fwd_is_load_i[k];
            end
            if (fwd_rd_en_i[k] && rs2_en && (rs2_idx_o != 5'd0) &&
                (rs2_idx_o == fwd_rd_idx_i[5*k +: 5])) begin
                rs2_val  = fwd_rd_wdata_i[XLEN*k +: XLEN];
                rs2_load = fwd_is_load_i[k];
            end
        end
    end

    assign hazard     = in_valid_i & (rs1_load | rs2_load);
    assign in_ready_o = (~out_valid_o | out_ready_i) & ~hazard & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_valid_o     <= 1'b0;
            out_pc_o        <= '0;
            out_instr_o     <= '0;
            out_rs1_rdata_o <= '0;
            out_rs2_rdata_o <= '0;
            out_imm_o       <= '0;
            out_rd_idx_o    <= '0;
            out_rd_en_o     <= 1'b0;
            out_illegal_o   <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            out_valid_o     <= 1'b1;
            out_pc_o        <= pc_i;
            out_instr_o     <= instr_i;
            out_rs1_rdata_o <= rs1_val;
            out_rs2_rdata_o <= rs2_val;
            out_imm_o       <= imm;
            out_rd_idx_o    <= rd;
            out_rd_en_o     <= rd_en;
            out_illegal_o   <= illegal;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
        end else if (hazard && !flush_i && (stall_cnt_o != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - self-checking bench for decode_stage_pipe
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic [31:0] rs1_rdata = '0;
    logic [31:0] rs2_rdata = '0;
    logic [1:0]  fwd_en = '0;
    logic [9:0]  fwd_idx = '0;
    logic [63:0] fwd_wdata = '0;
    logic [1:0]  fwd_load = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_rd_en, out_illegal;
    logic [4:0]  rs1_idx, rs2_idx, out_rd_idx;
    logic [31:0] out_pc, out_instr, out_r1, out_r2, out_imm;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2, out_rd_en2, out_illegal2;
    logic [4:0]  rs1_idx2, rs2_idx2, out_rd_idx2;
    logic [31:0] out_pc2, out_instr2, out_r12, out_r22, out_imm2;
    logic [1:0]  stall_cnt2;

    always #5 clk = ~clk;

    decode_stage_pipe dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .pc_i(pc), .instr_i(instr), .rs1_idx_o(rs1_idx), .rs2_idx_o(rs2_idx),
        .rs1_rdata_i(rs1_rdata), .rs2_rdata_i(rs2_rdata),
        .fwd_rd_en_i(fwd_en), .fwd_rd_idx_i(fwd_idx), .fwd_rd_wdata_i(fwd_wdata),
        .fwd_is_load_i(fwd_load), .flush_i(flush), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_pc_o(out_pc), .out_instr_o(out_instr),
        .out_rs1_rdata_o(out_r1), .out_rs2_rdata_o(out_r2), .out_imm_o(out_imm),
        .out_rd_idx_o(out_rd_idx), .out_rd_en_o(out_rd_en), .out_illegal_o(out_illegal),
        .stall_cnt_o(stall_cnt)
    );

    decode_stage_pipe #(.CNT_WIDTH(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .pc_i(pc), .instr_i(instr), .rs1_idx_o(rs1_idx2), .rs2_idx_o(rs2_idx2),
        .rs1_rdata_i(rs1_rdata), .rs2_rdata_i(rs2_rdata),
        .fwd_rd_en_i(fwd_en), .fwd_rd_idx_i(fwd_idx), .fwd_rd_wdata_i(fwd_wdata),
        .fwd_is_load_i(fwd_load), .flush_i(flush), .out_valid_o(out_valid2),
        .out_ready_i(out_ready), .out_pc_o(out_pc2), .out_instr_o(out_instr2),
        .out_rs1_rdata_o(out_r12), .out_rs2_rdata_o(out_r22), .out_imm_o(out_imm2),
        .out_rd_idx_o(out_rd_idx2), .out_rd_en_o(out_rd_en2), .out_illegal_o(out_illegal2),
        .stall_cnt_o(stall_cnt2)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        r1e, r2e, rde, ill;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t ref_dec(input logic [31:0] w);
        dec_t d;
        logic signed [31:0] s;
        logic [31:0] sign;
        s = $signed(w);
        sign = 32'(s >>> 31);
        d = '{r1e: 1'b0, r2e: 1'b0, rde: 1'b0, ill: 1'b0, imm: 32'd0};
        case (w[6:0])
            7'h13, 7'h03, 7'h67: begin
                d.r1e = 1; d.rde = 1; d.imm = 32'(s >>> 20);
            end
            7'h33: begin d.r1e = 1; d.r2e = 1; d.rde = 1; end
            7'h63: begin
                d.r1e = 1; d.r2e = 1;
                d.imm = (sign << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            end
            7'h6F: begin
                d.rde = 1;
                d.imm = (sign << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            end
            7'h37, 7'h17: begin d.rde = 1; d.imm = w & 32'hFFFF_F000; end
            7'h73: begin d.rde = 1; d.r1e = !w[14]; end
            7'h23: begin
                d.r1e = 1; d.r2e = 1;
                d.imm = 32'((s >>> 25) <<< 5) | 32'(w[11:7]);
            end
            default: d.ill = 1;
        endcase
        if (w[11:7] == 5'd0) d.rde = 0;
        return d;
    endfunction

    task automatic resolve(input logic [4:0] r, input logic en, input logic [31:0] rf,
                           output logic [31:0] v, output logic ld);
        v = rf;
        ld = 1'b0;
        if (en && r != 0) begin
            for (int k = 0; k < 2; k++) begin
                if (fwd_en[k] && fwd_idx[5*k +: 5] == r) begin
                    v = fwd_wdata[32*k +: 32];
                    ld = fwd_load[k];
                    break;
                end
            end
        end
    endtask

    logic        m_valid = 0, m_rde = 0, m_ill = 0;
    logic [31:0] m_pc = 0, m_instr = 0, m_r1 = 0, m_r2 = 0, m_imm = 0;
    logic [4:0]  m_rd = 0;
    int          m_cnt = 0, m_cnt2 = 0;

    task automatic step();
        dec_t d;
        logic [31:0] v1, v2;
        logic l1, l2, hz, rdy;
        #1;
        d = ref_dec(instr);
        resolve(instr[19:15], d.r1e, rs1_rdata, v1, l1);
        resolve(instr[24:20], d.r2e, rs2_rdata, v2, l2);
        hz = in_valid && (l1 || l2);
        rdy = (!m_valid || out_ready) && !hz && !flush;
        chk("in_ready", in_ready, rdy);
        chk("rs1_idx", rs1_idx, instr[19:15]);
        chk("rs2_idx", rs2_idx, instr[24:20]);
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_pc = 0; m_instr = 0; m_r1 = 0; m_r2 = 0; m_imm = 0;
            m_rd = 0; m_rde = 0; m_ill = 0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            if (hz && !flush) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (flush) m_valid = 0;
            else if (in_valid && rdy) begin
                m_valid = 1; m_pc = pc; m_instr = instr; m_r1 = v1; m_r2 = v2;
                m_imm = d.imm; m_rd = instr[11:7]; m_rde = d.rde; m_ill = d.ill;
            end else if (out_ready) m_valid = 0;
        end
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("out_pc", out_pc, m_pc);
        chk("out_instr", out_instr, m_instr);
        chk("out_rs1", out_r1, m_r1);
        chk("out_rs2", out_r2, m_r2);
        chk("out_imm", out_imm, m_imm);
        chk("out_rd_idx", out_rd_idx, m_rd);
        chk("out_rd_en", out_rd_en, m_rde);
        chk("out_illegal", out_illegal, m_ill);
        chk("stall_cnt", stall_cnt, m_cnt);
        chk("stall_cnt_sat", stall_cnt2, m_cnt2);
    endtask

    typedef struct {
        logic [31:0] instr, rf1, rf2, imm;
        logic        rde, ill;
    } vec_t;

    vec_t tbl[7];
    logic [6:0] opcs[11];

    localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
    localparam logic [31:0] ADD_X3_1_2 = 32'h0020_81B3;
    localparam logic [31:0] ADD_X3_1_0 = 32'h0000_81B3;

    initial begin
        tbl[0] = '{32'h0000_007F, 32'h11, 32'h22, 32'h0, 1'b0, 1'b1};
        tbl[1] = '{32'hFE00_0EE3, 32'h33, 32'h44, 32'hFFFF_FFFC, 1'b0, 1'b0};
        tbl[2] = '{32'h0000_0013, 32'h55, 32'h66, 32'h0, 1'b0, 1'b0};
        tbl[3] = '{32'h1234_52B7, 32'h77, 32'h88, 32'h1234_5000, 1'b1, 1'b0};
        tbl[4] = '{32'hFE20_AC23, 32'h99, 32'hAA, 32'hFFFF_FFF8, 1'b0, 1'b0};
        tbl[5] = '{32'h0080_00EF, 32'hBB, 32'hCC, 32'h8, 1'b1, 1'b0};
        tbl[6] = '{32'h3002_D0F3, 32'hDD, 32'hEE, 32'h0, 1'b1, 1'b0};
        opcs = '{7'h13, 7'h03, 7'h67, 7'h33, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h23, 7'h0F};

        // Bring the slot out of its unknown power-up state before modelling.
        rst_n = 0;
        @(posedge clk);
        #1;

        // Reset holds the slot empty even with a valid instruction present.
        in_valid = 1; instr = ADDI_X1_5; pc = 32'h100;
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_cnt", stall_cnt, 0);
        rst_n = 1;
        step();
        chk("first_valid", out_valid, 1);
        chk("first_imm", out_imm, 5);
        chk("first_rd", out_rd_idx, 1);
        chk("first_rd_en", out_rd_en, 1);

        // EX beats MEM on x1; x2 comes from the register file.
        instr = ADD_X3_1_2; pc = 32'h104; rs2_rdata = 32'h22; rs1_rdata = 32'h1;
        fwd_en = 2'b11; fwd_idx = {5'd1, 5'd1}; fwd_wdata = {32'hBBBB, 32'hAAAA};
        step();
        chk("fwd_rs1", out_r1, 32'hAAAA);
        chk("fwd_rs2", out_r2, 32'h22);

        // Load in EX on x1: stall three cycles, then MEM forwards the result.
        instr = ADD_X3_1_0; pc = 32'h108;
        fwd_en = 2'b01; fwd_idx = {5'd0, 5'd1}; fwd_load = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hz_ready", in_ready, 0);
            chk("hz_bubble", out_valid, 0);
        end
        chk("hz_cnt3", stall_cnt, 3);
        fwd_load = 2'b00; fwd_en = 2'b10; fwd_idx = {5'd1, 5'd0}; fwd_wdata = {32'h77, 32'h0};
        step();
        chk("lu_valid", out_valid, 1);
        chk("lu_rs1", out_r1, 32'h77);

        // Backpressure: slot frozen for four cycles.
        fwd_en = 0; instr = ADDI_X1_5; pc = 32'h10C; out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_ready", in_ready, 0);
            chk("bp_instr", out_instr, ADD_X3_1_0);
            chk("bp_rs1", out_r1, 32'h77);
            chk("bp_valid", out_valid, 1);
        end
        out_ready = 1;
        step();
        chk("bp_accept", out_instr, ADDI_X1_5);
        chk("bp_acc_valid", out_valid, 1);

        // Flush drops the slot and refuses the incoming instruction.
        flush = 1; instr = ADD_X3_1_2; pc = 32'h110;
        step();
        chk("fl_valid", out_valid, 0);
        chk("fl_hold", out_instr, ADDI_X1_5);
        flush = 0;

        // Saturation of the narrow counter after five hazard cycles.
        rst_n = 0;
        step();
        rst_n = 1;
        instr = ADD_X3_1_0; fwd_en = 2'b01; fwd_idx = {5'd0, 5'd1}; fwd_load = 2'b01;
        for (int i = 0; i < 5; i++) step();
        chk("sat_cnt2", stall_cnt2, 3);
        chk("sat_cnt16", stall_cnt, 5);
        fwd_en = 0; fwd_load = 0;

        foreach (tbl[i]) begin
            instr = tbl[i].instr; rs1_rdata = tbl[i].rf1; rs2_rdata = tbl[i].rf2;
            pc = 32'h200 + 32'(i) * 4;
            step();
            chk("tbl_valid", out_valid, 1);
            chk("tbl_imm", out_imm, tbl[i].imm);
            chk("tbl_rd_en", out_rd_en, tbl[i].rde);
            chk("tbl_illegal", out_illegal, tbl[i].ill);
            chk("tbl_rs1", out_r1, tbl[i].rf1);
            chk("tbl_rs2", out_r2, tbl[i].rf2);
        end

        for (int n = 0; n < 400; n++) begin
            logic [31:0] w;
            w = $urandom;
            w[6:0] = opcs[$urandom_range(0, 10)];
            w[11:7] = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            instr = w;
            pc = $urandom;
            rs1_rdata = $urandom;
            rs2_rdata = $urandom;
            fwd_en = 2'($urandom);
            fwd_idx = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            fwd_wdata = {$urandom, $urandom};
            fwd_load = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            in_valid = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
